cpu_synth_regs: RTL and testbench
=================================

# cpu_synth_regs

CPU-side memory-mapped register bank for the audio synthesizer, sitting directly upstream of the CPU-to-synth clock-domain crossing. Software writes staging registers through the MMIO bus. A write to the commit register atomically copies staging into the output registers. The block then runs a four-phase req/ack handshake so the crossing can sample a stable snapshot. Status (busy/pending) is readable so software can poll before reconfiguring.

## Interface
Parameters:
- N_VOICES, default 1, number of carrier voices; legal range 1–16.

Ports:
- clk  in  1  CPU clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mmio_we  in  1  write strobe for the synth address window.
- mmio_addr  in  8  byte offset within the window; bits [1:0] ignored.
- mmio_wdata  in  32  write data.
- mmio_rdata  out  32  registered read data, one-cycle latency.
- cpu_carrier_fcws  out  [N_VOICES-1:0][23:0]  committed carrier FCWs.
- cpu_mod_fcw  out  24  committed modulator FCW.
- cpu_mod_shift  out  5  committed modulator shift.
- cpu_note_en  out  N_VOICES  committed per-voice note enables.
- cpu_synth_shift  out  5  committed output shift.
- cpu_req  out  1  handshake request to the crossing.
- cpu_ack  in  1  handshake acknowledge from the crossing; already in the clk domain.

## Operation
Address map (byte offsets):
- 0x00+4*i: carrier FCW i, for i < N_VOICES.
- 0x40: mod_fcw.
- 0x44: mod_shift.
- 0x48: note_en.
- 0x4C: synth_shift.
- 0x50: commit (write-only; data ignored).
- 0x54: status, read-only: bit0 busy, bit1 pending, others 0.

Write behaviour:
- A write to a staging register takes the low-order bits of mmio_wdata (24, 5, or N_VOICES bits); upper bits are discarded.
- Writes to unmapped or read-only offsets, or to carrier slots with i ≥ N_VOICES, are ignored.

Commit and FSM (states IDLE, REQ, RELEASE):
- Define start = (commit write) OR pending, evaluated in IDLE.
- IDLE, start: copy all staging registers to the output registers, clear pending, go to REQ.
- REQ: cpu_req=1. When cpu_ack=1 is sampled, go to RELEASE.
- RELEASE: cpu_req=0. When cpu_ack=0 is sampled, go to IDLE.
- busy = (state != IDLE).
- A commit write while busy sets pending. Further commits while pending is set coalesce into one.
- Output registers change only on the IDLE start edge. They are stable for the whole time cpu_req is high and until the next start.
- Staging writes are accepted in any state and never disturb the outputs.
- A staging write on the same edge as a pending-triggered start: the snapshot takes the pre-write staging value; the new value remains in staging for the next commit.

Reads:
- mmio_rdata is loaded every cycle from the current mmio_addr.
- Unmapped offsets and offset 0x50 read 0.
- Register values are zero-extended to 32 bits.

## Timing
Reset values:
- All staging and output registers: 0.
- cpu_req = 0, mmio_rdata = 0, pending = 0, state = IDLE.

Reset mid-handshake: cpu_req is 0 on the cycle after reset is sampled. The system resets the crossing in the same reset event.

Latencies:
- Commit write sampled in IDLE at edge t: outputs updated and cpu_req=1 from t+1.
- cpu_ack=1 sampled at edge a: cpu_req=0 from a+1.
- cpu_ack=0 sampled at edge b in RELEASE: IDLE and busy=0 from b+1.
- With pending set: new snapshot and cpu_req=1 from b+2.
- Status read issued at edge s reflects state after edge s; data is visible at s+1.
- Minimum handshake is 3 cycles, given instant ack.

## Configuration
CPU_SYNTH_REGS_READBACK_EN:
- Defined: staging registers at 0x00–0x4C are readable.
- Undefined: those offsets read 0; only status is readable. Read mux and its registers are removed, but mmio_rdata remains registered.

## Test plan
- Reset, then read 0x54 and 0x48 → mmio_rdata 0 both; cpu_req=0; all outputs 0.
- Write 0x40=0xFF123456, then commit → next cycle cpu_mod_fcw=0x123456 and cpu_req=1. Ack high after 4 cycles → req low next cycle. Ack low → status reads busy=0.
- While in REQ, write 0x00=0x000ABC → cpu_carrier_fcws[0] unchanged until the next commit.
- Two commits during one handshake → status bit1=1. Exactly one extra handshake follows, starting 2 cycles after ack falls, carrying the latest staging values.
- Assert rst while cpu_req=1 → cpu_req=0 and outputs 0 on the next cycle; a subsequent commit works normally.
- With N_VOICES=2 and readback enabled: write 0x08 (invalid slot) and 0x48=0xFFFF → read 0x08=0 and 0x48=0x3.

Source files
------------

// File: rtl/cpu_synth_regs.sv
// cpu_synth_regs: MMIO staging registers, atomic commit snapshot and four-phase req/ack toward the synth domain.
// Optional CPU_SYNTH_REGS_READBACK_EN makes staging registers 0x00-0x4C readable.
module cpu_synth_regs #(
  parameter int N_VOICES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mmio_we,
  input  logic [7:0]               mmio_addr,
  input  logic [31:0]              mmio_wdata,
  output logic [31:0]              mmio_rdata,
  output logic [N_VOICES-1:0][23:0] cpu_carrier_fcws,
  output logic [23:0]              cpu_mod_fcw,
  output logic [4:0]               cpu_mod_shift,
  output logic [N_VOICES-1:0]      cpu_note_en,
  output logic [4:0]               cpu_synth_shift,
  output logic                     cpu_req,
  input  logic                     cpu_ack
);
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
  state_t state_q, state_d;
  logic pending_q, pending_d, req_q, start, commit_wr;
  logic [5:0] word;
  logic [N_VOICES-1:0][23:0] car_q, car_out_q;
  logic [23:0] mfcw_q, mfcw_out_q;
  logic [4:0] mshift_q, mshift_out_q, sshift_q, sshift_out_q;
  logic [N_VOICES-1:0] nen_q, nen_out_q;
  logic [31:0] status, rd_d, rdata_q;
  logic unused;
  assign unused = ^{mmio_addr[1:0], mmio_wdata[31:24]};
  assign word = mmio_addr[7:2];
  assign commit_wr = mmio_we && word == 6'h14;
  always_ff @(posedge clk) begin
    if (rst) begin
      car_q <= '0;
      mfcw_q <= '0;
      mshift_q <= '0;
      nen_q <= '0;
      sshift_q <= '0;
    end else if (mmio_we) begin
      for (int i = 0; i < N_VOICES; i++)
        if (word == 6'(i)) car_q[i] <= mmio_wdata[23:0];
      if (word == 6'h10) mfcw_q <= mmio_wdata[23:0];
      if (word == 6'h11) mshift_q <= mmio_wdata[4:0];
      if (word == 6'h12) nen_q <= mmio_wdata[N_VOICES-1:0];
      if (word == 6'h13) sshift_q <= mmio_wdata[4:0];
    end
  end
  // Snapshot uses pre-edge staging, so a same-edge staging write lands in the next commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      car_out_q <= '0;
      mfcw_out_q <= '0;
      mshift_out_q <= '0;
      nen_out_q <= '0;
      sshift_out_q <= '0;
    end else if (start) begin
      car_out_q <= car_q;
      mfcw_out_q <= mfcw_q;
      mshift_out_q <= mshift_q;
      nen_out_q <= nen_q;
      sshift_out_q <= sshift_q;
    end
  end
  always_comb begin
    start = state_q == IDLE && (commit_wr || pending_q);
    state_d = start ? REQ :
              (state_q == REQ && cpu_ack) ? RELEASE :
              (state_q == RELEASE && !cpu_ack) ? IDLE : state_q;
    pending_d = start ? 1'b0 : (state_q != IDLE && commit_wr) ? 1'b1 : pending_q;
  end
  // req comes straight from a flop so the crossing never sees decode glitches.
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    pending_q <= !rst && pending_d;
    req_q <= !rst && state_d == REQ;
  end
  assign status = {30'd0, pending_d, state_d != IDLE};
`ifdef CPU_SYNTH_REGS_READBACK_EN
  always_comb begin
    rd_d = word == 6'h10 ? 32'(mfcw_q) :
           word == 6'h11 ? 32'(mshift_q) :
           word == 6'h12 ? 32'(nen_q) :
           word == 6'h13 ? 32'(sshift_q) :
           word == 6'h15 ? status : '0;
    for (int i = 0; i < N_VOICES; i++)
      if (word == 6'(i)) rd_d = 32'(car_q[i]);
  end
`else
  assign rd_d = word == 6'h15 ? status : '0;
`endif
  always_ff @(posedge clk) rdata_q <= rst ? '0 : rd_d;
  assign mmio_rdata = rdata_q;
  assign cpu_carrier_fcws = car_out_q;
  assign cpu_mod_fcw = mfcw_out_q;
  assign cpu_mod_shift = mshift_out_q;
  assign cpu_note_en = nen_out_q;
  assign cpu_synth_shift = sshift_out_q;
  assign cpu_req = req_q;
endmodule

// File: tb/tb_cpu_synth_regs.sv
// tb_cpu_synth_regs: directed stimulus with a due-cycle scoreboard checked by an independent monitor.
module tb_cpu_synth_regs;
`ifdef CPU_SYNTH_REGS_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic clk = 0, rst = 1, mmio_we = 0, cpu_ack = 0;
  logic [7:0] mmio_addr = 0;
  logic [31:0] mmio_wdata = 0, mmio_rdata;
  logic [1:0][23:0] cpu_carrier_fcws;
  logic [23:0] cpu_mod_fcw;
  logic [4:0] cpu_mod_shift, cpu_synth_shift;
  logic [1:0] cpu_note_en;
  logic cpu_req;
  int cyc = 0, n_cmp = 0, n_err = 0;
  typedef struct {int kind; logic [31:0] exp; string name; int due;} item_t;
  item_t sb[$];

  cpu_synth_regs #(.N_VOICES(2)) dut (
    .clk(clk), .rst(rst), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .cpu_carrier_fcws(cpu_carrier_fcws), .cpu_mod_fcw(cpu_mod_fcw),
    .cpu_mod_shift(cpu_mod_shift), .cpu_note_en(cpu_note_en),
    .cpu_synth_shift(cpu_synth_shift), .cpu_req(cpu_req), .cpu_ack(cpu_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sel(int k);
    case (k)
      0: return mmio_rdata;
      1: return {31'd0, cpu_req};
      2: return {8'd0, cpu_mod_fcw};
      3: return {8'd0, cpu_carrier_fcws[0]};
      4: return {8'd0, cpu_carrier_fcws[1]};
      5: return {30'd0, cpu_note_en};
      6: return {27'd0, cpu_synth_shift};
      default: return {27'd0, cpu_mod_shift};
    endcase
  endfunction

  always @(negedge clk)
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      item_t it;
      logic [31:0] act;
      it = sb.pop_front();
      act = sel(it.kind);
      n_cmp++;
      if (act !== it.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end

  task automatic expect_after_edge(int kind, logic [31:0] v, string name);
    sb.push_back('{kind, v, name, cyc + 1});
  endtask
  task automatic wr(logic [7:0] a, logic [31:0] d);
    mmio_we = 1; mmio_addr = a; mmio_wdata = d;
  endtask
  task automatic rd(logic [7:0] a, logic [31:0] v, string name);
    mmio_we = 0; mmio_addr = a;
    expect_after_edge(0, v, name);
  endtask
  task automatic step();
    @(negedge clk);
    mmio_we = 0;
  endtask

  initial begin
    repeat (3) step();
    rst = 0;
    rd(8'h54, 0, "reset_status");
    expect_after_edge(1, 0, "reset_req");
    expect_after_edge(2, 0, "reset_mod_fcw");
    expect_after_edge(3, 0, "reset_car0");
    expect_after_edge(5, 0, "reset_note_en");
    step();
    rd(8'h48, 0, "reset_note_en_rd"); step();
    // basic commit and handshake
    wr(8'h40, 32'hFF123456); step();
    wr(8'h50, 32'hDEAD);
    expect_after_edge(1, 1, "commit_req");
    expect_after_edge(2, 32'h123456, "commit_mod_fcw");
    step();
    expect_after_edge(1, 1, "req_hold1"); step();
    expect_after_edge(1, 1, "req_hold2"); step();
    expect_after_edge(1, 1, "req_hold3"); step();
    wr(8'h00, 32'h000ABC);
    expect_after_edge(3, 0, "car0_stable_in_req");
    step();
    cpu_ack = 1;
    rd(8'h54, 1, "status_release");
    expect_after_edge(1, 0, "req_drop");
    step();
    cpu_ack = 0;
    rd(8'h54, 0, "status_idle");
    expect_after_edge(3, 0, "car0_still_old");
    step();
    // coalesced commits during one handshake
    wr(8'h50, 0);
    expect_after_edge(1, 1, "c2_req");
    expect_after_edge(3, 32'hABC, "c2_car0");
    step();
    wr(8'h50, 0); step();
    wr(8'h50, 0); step();
    wr(8'h40, 32'h777); step();
    rd(8'h54, 3, "status_busy_pending"); step();
    cpu_ack = 1;
    expect_after_edge(1, 0, "c2_req_drop");
    step();
    cpu_ack = 0;
    rd(8'h54, 2, "status_idle_pending");
    expect_after_edge(1, 0, "gap_req_low");
    step();
    wr(8'h40, 32'h999);
    expect_after_edge(1, 1, "extra_req");
    expect_after_edge(2, 32'h777, "extra_snapshot_prewrite");
    step();
    rd(8'h54, 1, "status_busy_no_pending"); step();
    cpu_ack = 1; step();
    cpu_ack = 0; step();
    rd(8'h54, 0, "no_second_extra");
    expect_after_edge(1, 0, "no_second_req");
    step();
    rd(8'h40, RB ? 32'h999 : 32'h0, "rd_mod_fcw_staging"); step();
    // reset mid-handshake
    wr(8'h50, 0);
    expect_after_edge(2, 32'h999, "pre_rst_snapshot");
    step();
    rst = 1;
    expect_after_edge(1, 0, "rst_req");
    expect_after_edge(2, 0, "rst_mod_fcw");
    step();
    rst = 0;
    wr(8'h4C, 32'hFFFFFFFF); step();
    wr(8'h48, 32'hFFFF); step();
    wr(8'h44, 32'hFFFFFFE3); step();
    wr(8'h50, 0);
    expect_after_edge(1, 1, "post_rst_req");
    expect_after_edge(6, 5'h1F, "post_rst_synth_shift");
    expect_after_edge(5, 3, "post_rst_note_en");
    expect_after_edge(7, 3, "post_rst_mod_shift");
    expect_after_edge(2, 0, "post_rst_mod_fcw");
    step();
    cpu_ack = 1; step();
    cpu_ack = 0; step();
    // slot decoding with two voices
    wr(8'h08, 32'h123); step();
    wr(8'h04, 32'h01000123); step();
    rd(8'h08, 0, "rd_invalid_slot"); step();
    rd(8'h48, RB ? 32'h3 : 32'h0, "rd_note_en"); step();
    rd(8'h04, RB ? 32'h123 : 32'h0, "rd_car1"); step();
    rd(8'h50, 0, "rd_commit"); step();
    rd(8'h54, 0, "rd_status_final");
    expect_after_edge(4, 0, "car1_not_committed");
    step();
    repeat (3) step();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
